// File: rtl/wb_stage_ctrl.sv
// wb_stage_ctrl -- memory-access / write-back stage controller.
//
// Takes one instruction at a time from upstream. ALU and jump results are
// written to the register file one cycle after acceptance. Loads and stores
// make a request on the data-memory port and wait for an acknowledge, with a
// bounded wait. Load data is extended by access size before write-back.
//
// Optional feature macro: WB_LOAD_FWD_EN adds fwd_pend / fwd_rd, which flag a
// load whose destination register has not been written yet.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_inst             instruction word (opcode, funct3, rd)
//   in_alu              ALU result, also the memory address
//   in_rs2              store data
//   in_pc4              PC+4, written back for jumps
//   flush               discard the in-flight instruction
//   dmem_*              data-memory request/response
//   rf_we/waddr/wdata   register-file write port
//   timeout_err         sticky flag, set when a memory access times out
//   fwd_pend, fwd_rd    (WB_LOAD_FWD_EN only) pending load destination
module wb_stage_ctrl #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc4,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [1:0]      dmem_size,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            timeout_err
`ifdef WB_LOAD_FWD_EN
  ,
  output logic            fwd_pend,
  output logic [4:0]      fwd_rd
`endif
);

  // Counter only has to hold 0 .. ACK_TIMEOUT-1.
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_terr, w_terr_next;
  logic            r_req, w_req_next;
  logic            r_dwe, w_dwe_next;
  logic [1:0]      r_size, w_size_next;
  logic [XLEN-1:0] r_addr, w_addr_next;
  logic [XLEN-1:0] r_wdata, w_wdata_next;
  logic            r_is_load, w_is_load_next;
  logic [2:0]      r_lf3, w_lf3_next;
  logic [4:0]      r_rd, w_rd_next;
  logic            r_flushed, w_flushed_next;
  logic            r_rf_we, w_rf_we_next;
  logic [XLEN-1:0] r_rf_wdata, w_rf_wdata_next;

  logic [4:0]      w_opc;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  logic            w_is_alu, w_is_jmp, w_ld_ok, w_st_ok;
  logic            w_accept, w_tmo;
  logic [XLEN-1:0] w_ext;
  logic            w_unused;

  assign w_opc = in_inst[6:2];
  assign w_f3  = in_inst[14:12];
  assign w_rd  = in_inst[11:7];
  assign w_unused = ^{in_inst[31:15], in_inst[1:0]};

  assign w_is_alu = (w_opc == 5'b01100) || (w_opc == 5'b00100);
  assign w_is_jmp = (w_opc == 5'b11011) || (w_opc == 5'b11001);
  // Loads/stores with an illegal funct3 fall through to "retire, no write".
  assign w_ld_ok  = (w_opc == 5'b00000) &&
                    ((w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                     (w_f3 == 3'b100) || (w_f3 == 3'b101) ||
                     ((XLEN == 64) && ((w_f3 == 3'b011) || (w_f3 == 3'b110))));
  assign w_st_ok  = (w_opc == 5'b01000) &&
                    ((w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                     ((XLEN == 64) && (w_f3 == 3'b011)));

  assign in_ready = rst_n && (r_state == S_IDLE) && !flush;
  assign w_accept = in_valid && in_ready;
  // Last no-ack MEM cycle; an ack arriving in this same cycle still wins.
  assign w_tmo    = (r_state == S_MEM) && !dmem_ack && (r_cnt == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    w_ext = dmem_rdata;
    case (r_lf3)
      3'b000:  w_ext = XLEN'($signed(dmem_rdata[7:0]));
      3'b001:  w_ext = XLEN'($signed(dmem_rdata[15:0]));
      3'b010:  w_ext = XLEN'($signed(dmem_rdata[31:0]));
      3'b100:  w_ext = XLEN'(dmem_rdata[7:0]);
      3'b101:  w_ext = XLEN'(dmem_rdata[15:0]);
      3'b110:  w_ext = XLEN'(dmem_rdata[31:0]);
      default: w_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_terr_next     = r_terr;
    w_req_next      = r_req;
    w_dwe_next      = r_dwe;
    w_size_next     = r_size;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_is_load_next  = r_is_load;
    w_lf3_next      = r_lf3;
    w_rd_next       = r_rd;
    w_flushed_next  = r_flushed;
    w_rf_we_next    = 1'b0;
    w_rf_wdata_next = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_rd_next      = w_rd;
          w_flushed_next = 1'b0;
          if (w_ld_ok || w_st_ok) begin
            w_state_next   = S_MEM;
            w_cnt_next     = '0;
            w_req_next     = 1'b1;
            w_dwe_next     = w_st_ok;
            w_size_next    = w_f3[1:0];
            w_addr_next    = in_alu;
            w_wdata_next   = w_st_ok ? in_rs2 : '0;
            w_is_load_next = w_ld_ok;
            w_lf3_next     = w_f3;
          end else begin
            w_state_next = S_WB;
            w_rf_we_next = (w_is_alu || w_is_jmp) && (w_rd != 5'd0);
            if (w_rf_we_next)
              w_rf_wdata_next = w_is_alu ? in_alu : in_pc4;
          end
        end
      end
      S_MEM: begin
        if (flush)
          w_flushed_next = 1'b1;
        if (dmem_ack || w_tmo) begin
          w_req_next   = 1'b0;
          w_dwe_next   = 1'b0;
          w_size_next  = 2'b00;
          w_addr_next  = '0;
          w_wdata_next = '0;
        end
        if (dmem_ack) begin
          if (r_is_load) begin
            // Flushed loads still pass through WB, just without a write.
            w_state_next = S_WB;
            w_rf_we_next = !(r_flushed || flush) && (r_rd != 5'd0);
            if (w_rf_we_next)
              w_rf_wdata_next = w_ext;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (w_tmo) begin
          w_state_next = S_IDLE;
          w_terr_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_terr     <= 1'b0;
      r_req      <= 1'b0;
      r_dwe      <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_load  <= 1'b0;
      r_lf3      <= 3'b000;
      r_rd       <= 5'd0;
      r_flushed  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_wdata <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_terr     <= w_terr_next;
      r_req      <= w_req_next;
      r_dwe      <= w_dwe_next;
      r_size     <= w_size_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_is_load  <= w_is_load_next;
      r_lf3      <= w_lf3_next;
      r_rd       <= w_rd_next;
      r_flushed  <= w_flushed_next;
      r_rf_we    <= w_rf_we_next;
      r_rf_wdata <= w_rf_wdata_next;
    end
  end

  assign dmem_req    = r_req;
  assign dmem_we     = r_dwe;
  assign dmem_size   = r_size;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign timeout_err = r_terr;
  // A flush arriving during the WB cycle itself still cancels the write.
  assign rf_we    = r_rf_we && !flush;
  assign rf_waddr = rf_we ? r_rd : 5'd0;
  assign rf_wdata = rf_we ? r_rf_wdata : '0;

`ifdef WB_LOAD_FWD_EN
  logic r_fwd;

  // Set for a load with rd!=0 from acceptance through its WB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fwd <= 1'b0;
    else if (w_accept)
      r_fwd <= w_ld_ok && (w_rd != 5'd0);
    else if (flush || w_tmo || (r_state == S_WB))
      r_fwd <= 1'b0;
  end

  assign fwd_pend = r_fwd && !flush;
  assign fwd_rd   = fwd_pend ? r_rd : 5'd0;
`endif

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Self-checking bench for wb_stage_ctrl: a transaction-level model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_wb_stage_ctrl;
  localparam int XLEN = 32;
  localparam int ACK_TIMEOUT = 15;

  logic clk, rst_n, in_valid, flush, dmem_ack;
  logic [31:0] in_inst;
  logic [XLEN-1:0] in_alu, in_rs2, in_pc4, dmem_rdata;
  logic in_ready, dmem_req, dmem_we, rf_we, timeout_err;
  logic [1:0] dmem_size;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, rf_wdata;
  logic [4:0] rf_waddr;
`ifdef WB_LOAD_FWD_EN
  logic fwd_pend;
  logic [4:0] fwd_rd;
`endif

  int errors = 0;
  int checks = 0;
  int req_cycles = 0;
  int base;

  wb_stage_ctrl #(.XLEN(XLEN), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_alu(in_alu), .in_rs2(in_rs2), .in_pc4(in_pc4),
    .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
`ifdef WB_LOAD_FWD_EN
    .fwd_pend(fwd_pend), .fwd_rd(fwd_rd),
`endif
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // kind: 0 retire-no-write, 1 ALU write, 2 PC+4 write, 3 load, 4 store
  function automatic int classify(input logic [31:0] inst);
    logic [4:0] op;
    logic [2:0] f3;
    op = inst[6:2];
    f3 = inst[14:12];
    if (op == 5'b01100 || op == 5'b00100) return 1;
    if (op == 5'b11011 || op == 5'b11001) return 2;
    if (op == 5'b00000) begin
      if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) return 3;
      if (XLEN == 64 && f3 inside {3'd3, 3'd6}) return 3;
      return 0;
    end
    if (op == 5'b01000) begin
      if (f3 inside {3'd0, 3'd1, 3'd2}) return 4;
      if (XLEN == 64 && f3 == 3'd3) return 4;
      return 0;
    end
    return 0;
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [63:0] raw, input logic [2:0] f3);
    int bits;
    longint unsigned mask, v;
    bits = 8 << f3[1:0];
    mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    v = raw & mask;
    if (!f3[2] && (((v >> (bits - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
    return v[XLEN-1:0];
  endfunction

  bit m_mem, m_wb, m_ld, m_st, m_flushed, m_terr, m_fwd, m_wb_we;
  int m_n;
  logic [1:0] m_size;
  logic [2:0] m_f3;
  logic [4:0] m_rd;
  logic [XLEN-1:0] m_addr, m_wdata, m_wb_data;

  // Compare the DUT against the model for this cycle, then advance the model
  // with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_dmem_we", dmem_we, 0);
      chk("rst_dmem_addr", dmem_addr, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_timeout_err", timeout_err, 0);
      m_mem = 0; m_wb = 0; m_terr = 0; m_fwd = 0;
    end else begin
      logic e_rfwe;
      e_rfwe = m_wb && m_wb_we && !flush;
      chk("m_in_ready", in_ready, !m_mem && !m_wb && !flush);
      chk("m_dmem_req", dmem_req, m_mem);
      chk("m_dmem_we", dmem_we, m_mem && m_st);
      chk("m_dmem_size", dmem_size, m_mem ? m_size : 2'b00);
      chk("m_dmem_addr", dmem_addr, m_mem ? m_addr : '0);
      chk("m_dmem_wdata", dmem_wdata, m_mem ? m_wdata : '0);
      chk("m_rf_we", rf_we, e_rfwe);
      chk("m_rf_waddr", rf_waddr, e_rfwe ? m_rd : 5'd0);
      chk("m_rf_wdata", rf_wdata, e_rfwe ? m_wb_data : '0);
      chk("m_timeout_err", timeout_err, m_terr);
`ifdef WB_LOAD_FWD_EN
      chk("m_fwd_pend", fwd_pend, m_fwd && !flush);
      chk("m_fwd_rd", fwd_rd, (m_fwd && !flush) ? m_rd : 5'd0);
`endif
      if (dmem_req) req_cycles++;

      if (m_wb) begin
        m_wb = 0;
        m_fwd = 0;
      end else if (m_mem) begin
        if (flush) begin
          m_flushed = 1;
          m_fwd = 0;
        end
        m_n++;
        if (dmem_ack) begin
          m_mem = 0;
          if (m_ld) begin
            m_wb = 1;
            m_wb_we = !m_flushed && (m_rd != 0);
            m_wb_data = extend(64'(dmem_rdata), m_f3);
          end
        end else if (m_n == ACK_TIMEOUT) begin
          m_mem = 0;
          m_terr = 1;
          m_fwd = 0;
        end
      end else if (in_valid && !flush) begin
        int kind;
        kind = classify(in_inst);
        m_rd = in_inst[11:7];
        if (kind >= 3) begin
          m_mem = 1; m_n = 0; m_flushed = 0;
          m_ld = (kind == 3); m_st = (kind == 4);
          m_f3 = in_inst[14:12];
          m_size = m_f3[1:0];
          m_addr = in_alu;
          m_wdata = m_st ? in_rs2 : '0;
          m_fwd = m_ld && (m_rd != 0);
        end else begin
          m_wb = 1;
          m_wb_we = (kind != 0) && (m_rd != 0);
          m_wb_data = (kind == 1) ? in_alu : in_pc4;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [XLEN-1:0] alu,
                       input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] pc4);
    in_valid = 1'b1; in_inst = inst; in_alu = alu; in_rs2 = rs2; in_pc4 = pc4;
    cyc();
    in_valid = 1'b0; in_inst = '0; in_alu = '0; in_rs2 = '0; in_pc4 = '0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; dmem_ack = 1'b0;
    in_inst = '0; in_alu = '0; in_rs2 = '0; in_pc4 = '0; dmem_rdata = '0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_timeout_err", timeout_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // ADD x5: write 0x1234 in the single WB cycle
    issue(32'h000002B3, 'h1234, 0, 'h4);
    @(negedge clk);
    chk("add_rf_we", rf_we, 1);
    chk("add_rf_waddr", rf_waddr, 5);
    chk("add_rf_wdata", rf_wdata, 32'h00001234);
    chk("add_in_ready_busy", in_ready, 0);
    cyc();
    @(negedge clk);
    chk("add_rf_we_after", rf_we, 0);
    chk("add_in_ready_after", in_ready, 1);
    cyc();

    // LB x3, ack on the third request cycle
    dmem_rdata = 'h80;
    base = req_cycles;
    issue(32'h00000183, 'h40, 0, 0);
    @(negedge clk);
    chk("lb_req", dmem_req, 1);
    chk("lb_size", dmem_size, 0);
    cyc();
    cyc(); dmem_ack = 1'b1;
    cyc(); dmem_ack = 1'b0;
    @(negedge clk);
    chk("lb_rf_we", rf_we, 1);
    chk("lb_rf_waddr", rf_waddr, 3);
    chk("lb_rf_wdata", rf_wdata, 32'hFFFFFF80);
    cyc();
    chk("lb_req_cycles", req_cycles - base, 3);

    // LBU x3, same data zero-extended
    issue(32'h00004183, 'h40, 0, 0);
    cyc();
    cyc(); dmem_ack = 1'b1;
    cyc(); dmem_ack = 1'b0;
    @(negedge clk);
    chk("lbu_rf_wdata", rf_wdata, 32'h00000080);
    cyc();

    // SW with immediate ack
    base = req_cycles;
    issue(32'h00002023, 'h100, 'hCAFEBABE, 0);
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("sw_req", dmem_req, 1);
    chk("sw_we", dmem_we, 1);
    chk("sw_size", dmem_size, 2);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_wdata", dmem_wdata, 32'hCAFEBABE);
    cyc(); dmem_ack = 1'b0;
    @(negedge clk);
    chk("sw_req_after", dmem_req, 0);
    chk("sw_rf_we", rf_we, 0);
    chk("sw_in_ready", in_ready, 1);
    cyc();
    chk("sw_req_cycles", req_cycles - base, 1);

    // LW x9 with no ack: timeout
    base = req_cycles;
    issue(32'h00002483, 'h200, 0, 0);
    repeat (14) cyc();
    @(negedge clk);
    chk("tmo_req_last", dmem_req, 1);
    chk("tmo_err_before", timeout_err, 0);
    cyc();
    @(negedge clk);
    chk("tmo_req_dropped", dmem_req, 0);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_in_ready", in_ready, 1);
    chk("tmo_rf_we", rf_we, 0);
    repeat (3) cyc();
    chk("tmo_req_cycles", req_cycles - base, 15);
    chk("tmo_err_sticky", timeout_err, 1);

    // Flush during MEM of LW x7
    dmem_rdata = 'h12345678;
    issue(32'h00002383, 'h300, 0, 0);
`ifdef WB_LOAD_FWD_EN
    @(negedge clk);
    chk("fl_fwd_pend_before", fwd_pend, 1);
    chk("fl_fwd_rd_before", fwd_rd, 7);
`endif
    cyc(); flush = 1'b1;
    @(negedge clk);
    chk("fl_req_held", dmem_req, 1);
    chk("fl_in_ready", in_ready, 0);
`ifdef WB_LOAD_FWD_EN
    chk("fl_fwd_pend_after", fwd_pend, 0);
`endif
    cyc(); flush = 1'b0; dmem_ack = 1'b1;
    cyc(); dmem_ack = 1'b0;
    @(negedge clk);
    chk("fl_rf_we", rf_we, 0);
    chk("fl_req_done", dmem_req, 0);
    cyc();

    // Instruction offered while flush is high is not accepted
    flush = 1'b1;
    issue(32'h000002B3, 'h99, 0, 0);
    flush = 1'b0;
    @(negedge clk);
    chk("fl_idle_rf_we", rf_we, 0);
    chk("fl_idle_ready", in_ready, 1);
    cyc();

    // JAL x1 writes PC+4
    issue(32'h000000EF, 'h5, 0, 'h80000004);
    @(negedge clk);
    chk("jal_rf_wdata", rf_wdata, 32'h80000004);
    chk("jal_rf_waddr", rf_waddr, 1);
    cyc();

    // ADD x0: no write
    issue(32'h00000033, 'h77, 0, 0);
    @(negedge clk);
    chk("x0_rf_we", rf_we, 0);
    cyc();

    // LH x4 sign extension
    dmem_rdata = 'h00008001;
    issue(32'h00001203, 'h10, 0, 0);
    dmem_ack = 1'b1;
    cyc(); dmem_ack = 1'b0;
    @(negedge clk);
    chk("lh_rf_wdata", rf_wdata, 32'hFFFF8001);
    cyc();

    // LD is illegal at XLEN=32: no request, no write
    issue(32'h00003203, 'h10, 0, 0);
    @(negedge clk);
    chk("ld32_req", dmem_req, 0);
    chk("ld32_rf_we", rf_we, 0);
    cyc();

    // Unknown opcode retires silently
    issue(32'h0000000F, 'h10, 0, 0);
    cyc();

    // Flush in WB suppresses the write
    issue(32'h00000333, 'h66, 0, 0);
    flush = 1'b1;
    @(negedge clk);
    chk("wbflush_rf_we", rf_we, 0);
    cyc(); flush = 1'b0;
    cyc();

    // Reset asserted mid-MEM
    issue(32'h00002383, 'h400, 0, 0);
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmem_req", dmem_req, 0);
    chk("rstmem_ready", in_ready, 0);
    chk("rstmem_err", timeout_err, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    issue(32'h000002B3, 'h99, 0, 0);
    @(negedge clk);
    chk("post_rst_rf_we", rf_we, 1);
    chk("post_rst_rf_wdata", rf_wdata, 32'h99);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
